// File: rtl/hilo_md_unit.sv
// HI/LO owner for the MIPS core: iterative radix-2 mult/multu/div/divu plus mthi/mtlo/mfhi/mflo.
// Raises a Decode stall while a HI/LO consumer would see an unfinished result.
module hilo_md_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  i_CLK,
    input  logic                  i_RST_n,
    input  logic                  i_MdStartE,
    input  logic [1:0]            i_MdOpE,
    input  logic [DATA_WIDTH-1:0] i_SrcAE,
    input  logic [DATA_WIDTH-1:0] i_SrcBE,
    input  logic                  i_MthiE,
    input  logic                  i_MtloE,
    input  logic                  i_MfhiE,
    input  logic                  i_HiLoUseD,
    output logic [DATA_WIDTH-1:0] o_HiLoOutE,
    output logic                  o_MdStallD,
    output logic                  o_MdBusy
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t                 state_q;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [W-1:0]           hi_q, lo_q;
    logic [2*W-1:0]         acc_q, acc_d;
    logic [W-1:0]           opb_q;
    logic [W-1:0]           rawa_q;
    logic                   is_div_q, neg_q, neg_rem_q, bzero_q;

    logic                   sign_a, sign_b;
    logic [W-1:0]           mag_a, mag_b;
    logic [W:0]             mul_add, div_trial;
    logic [2*W-1:0]         mul_nxt, div_nxt, prod;
    logic [W-1:0]           quo, rem;

    always_comb begin
        sign_a    = ~i_MdOpE[0] & i_SrcAE[W-1];
        sign_b    = ~i_MdOpE[0] & i_SrcBE[W-1];
        mag_a     = sign_a ? -i_SrcAE : i_SrcAE;
        mag_b     = sign_b ? -i_SrcBE : i_SrcBE;
        // Multiply: multiplier sits in the low half and shifts out as partial sums shift in.
        mul_add   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opb_q} : {(W+1){1'b0}});
        mul_nxt   = {mul_add, acc_q[W-1:1]};
        // Divide: remainder in the high half, dividend shifts into it, quotient bits fill the low half.
        div_trial = acc_q[2*W-1:W-1] - {1'b0, opb_q};
        div_nxt   = div_trial[W] ? {acc_q[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        acc_d     = is_div_q ? div_nxt : mul_nxt;
        prod      = neg_q ? -acc_q : acc_q;
        quo       = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
        rem       = neg_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
    end

    always_ff @(posedge i_CLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            acc_q     <= '0;
            opb_q     <= '0;
            rawa_q    <= '0;
            is_div_q  <= 1'b0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_MdStartE) begin
                        is_div_q  <= i_MdOpE[1];
                        neg_q     <= sign_a ^ sign_b;
                        neg_rem_q <= sign_a;
                        bzero_q   <= (i_SrcBE == '0);
                        rawa_q    <= i_SrcAE;
                        cnt_q     <= '0;
                        if (i_MdOpE[1]) begin
                            acc_q <= {{W{1'b0}}, mag_a};
                            opb_q <= mag_b;
                        end else begin
                            acc_q <= {{W{1'b0}}, mag_b};
                            opb_q <= mag_a;
                        end
                        state_q <= CALC;
                    end else begin
                        if (i_MthiE) hi_q <= i_SrcAE;
                        if (i_MtloE) lo_q <= i_SrcAE;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CNT_WIDTH'(1);
                    if (cnt_q == CNT_WIDTH'(W-1)) state_q <= FIX;
                end
                FIX: begin
                    if (!is_div_q) begin
                        hi_q <= prod[2*W-1:W];
                        lo_q <= prod[W-1:0];
                    end else if (bzero_q) begin
                        // Divide by zero is not trapped: all-ones quotient, dividend passes through.
                        hi_q <= rawa_q;
                        lo_q <= '1;
                    end else begin
                        hi_q <= rem;
                        lo_q <= quo;
                    end
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_MdBusy   = (state_q != IDLE);
    assign o_MdStallD = i_HiLoUseD && (o_MdBusy || i_MdStartE);
    assign o_HiLoOutE = i_MfhiE ? hi_q : lo_q;

endmodule

// File: tb/tb_hilo_md_unit.sv
// Scoreboard bench for hilo_md_unit: directed ops push expectations, a monitor compares
// point observations, busy run lengths and stall run lengths as the DUT presents them.
module tb_hilo_md_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0, b = '0;
    logic        mthi = 1'b0, mtlo = 1'b0, mfhi = 1'b0, use_d = 1'b0;
    logic [31:0] out;
    logic        stall, busy;

    hilo_md_unit #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .i_CLK(clk), .i_RST_n(rst_n), .i_MdStartE(start), .i_MdOpE(op),
        .i_SrcAE(a), .i_SrcBE(b), .i_MthiE(mthi), .i_MtloE(mtlo),
        .i_MfhiE(mfhi), .i_HiLoUseD(use_d),
        .o_HiLoOutE(out), .o_MdStallD(stall), .o_MdBusy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          sel;   // 0 = o_HiLoOutE, 1 = o_MdStallD, 2 = o_MdBusy
        logic [31:0] exp;
    } chk_t;

    chk_t pq[$];
    int   bq[$], sq[$];
    int   n_cmp = 0, n_err = 0;
    logic obs_vld = 1'b0;
    int   brun = 0, srun = 0;
    chk_t e;
    logic [31:0] act;
    int   r;

    always @(negedge clk) begin
        if (obs_vld) begin
            n_cmp++;
            if (pq.size() == 0) begin
                n_err++;
                $display("FAIL point: observation with no expected entry");
            end else begin
                e = pq.pop_front();
                case (e.sel)
                    0:       act = out;
                    1:       act = {31'b0, stall};
                    default: act = {31'b0, busy};
                endcase
                if (act !== e.exp) begin
                    n_err++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
        if (busy) brun++;
        else if (brun > 0) begin
            n_cmp++;
            r = (bq.size() > 0) ? bq.pop_front() : -1;
            if (brun != r) begin
                n_err++;
                $display("FAIL busy_run: got %0d cycles expected %0d", brun, r);
            end
            brun = 0;
        end
        if (stall) srun++;
        else if (srun > 0) begin
            n_cmp++;
            r = (sq.size() > 0) ? sq.pop_front() : -1;
            if (srun != r) begin
                n_err++;
                $display("FAIL stall_run: got %0d cycles expected %0d", srun, r);
            end
            srun = 0;
        end
    end

    always @(negedge clk)
        if (rst_n && busy)
            assert (!(start || mthi || mtlo)) else $error("start/move issued while busy");

    task automatic chk(input string nm, input int sel, input logic [31:0] exp);
        chk_t c;
        c.name = nm; c.sel = sel; c.exp = exp;
        pq.push_back(c);
        obs_vld = 1'b1;
        @(posedge clk); #1;
        obs_vld = 1'b0;
    endtask

    task automatic do_md(input string nm, input logic [1:0] o, input logic [31:0] sa,
                         input logic [31:0] sb, input logic [31:0] ehi, input logic [31:0] elo,
                         input logic u, input logic mid, input logic mv);
        start = 1'b1; op = o; a = sa; b = sb; use_d = u; mthi = mv;
        bq.push_back(33);
        if (u) sq.push_back(34);
        @(posedge clk); #1;
        start = 1'b0; mthi = 1'b0;
        if (mid) begin
            repeat (3) @(posedge clk);
            #1;
            chk({nm, "_nostall"}, 1, 32'd0);
            chk({nm, "_busy"}, 2, 32'd1);
        end
        for (int i = 0; i < 50; i++) begin
            if (!busy) break;
            @(posedge clk); #1;
        end
        if (busy) begin
            n_cmp++; n_err++;
            $display("FAIL %s_timeout: busy still 1 expected 0", nm);
        end
        use_d = 1'b0;
        mfhi = 1'b1; chk({nm, "_hi"}, 0, ehi);
        mfhi = 1'b0; chk({nm, "_lo"}, 0, elo);
    endtask

    initial begin
        @(posedge clk); #1;
        chk("rst_out", 0, 32'd0);
        chk("rst_busy", 2, 32'd0);
        mfhi = 1'b1; chk("rst_hi", 0, 32'd0); mfhi = 1'b0;
        start = 1'b1; use_d = 1'b1;
        sq.push_back(1);
        chk("rst_stall", 1, 32'd1);
        start = 1'b0; use_d = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        mthi = 1'b1; a = 32'h0000_1234;
        @(posedge clk); #1;
        mthi = 1'b0; mfhi = 1'b1;
        chk("mthi_hi", 0, 32'h0000_1234);
        mfhi = 1'b0; chk("mthi_lo_kept", 0, 32'd0);
        mthi = 1'b1; mtlo = 1'b1; a = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        mthi = 1'b0; mtlo = 1'b0;
        mfhi = 1'b1; chk("mthilo_hi", 0, 32'hA5A5_A5A5);
        mfhi = 1'b0; chk("mthilo_lo", 0, 32'hA5A5_A5A5);

        do_md("mult",   2'b00, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0, 1'b0);
        do_md("multu",  2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        do_md("div",    2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0);
        do_md("divu",   2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 1'b1, 1'b0);
        do_md("divovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        do_md("divu0",  2'b11, 32'h64, 32'd0, 32'h64, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_md("div0",   2'b10, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        do_md("stall",  2'b00, 32'h10, 32'h20, 32'd0, 32'h200, 1'b1, 1'b0, 1'b0);

        // Abandon a multiply once the counter reaches 10.
        start = 1'b1; op = 2'b00; a = 32'd9; b = 32'd9;
        bq.push_back(10);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        chk("rstmid_busy", 2, 32'd0);
        mfhi = 1'b1; chk("rstmid_hi", 0, 32'd0);
        mfhi = 1'b0; chk("rstmid_lo", 0, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mfhi = 1'b0; chk("post_rst_lo", 0, 32'd0);

        do_md("mult67", 2'b00, 32'd6, 32'd7, 32'd0, 32'd42, 1'b0, 1'b0, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        if (pq.size() != 0 || bq.size() != 0 || sq.size() != 0) begin
            n_cmp++; n_err++;
            $display("FAIL leftover: %0d/%0d/%0d entries pending expected 0",
                     pq.size(), bq.size(), sq.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Iterative multiply/divide unit owning the HI/LO registers of the pipelined MIPS core. It accepts mult/multu/div/divu from the Execute stage and computes them over several cycles while independent instructions keep flowing. It originates a stall request toward the hazard logic whenever a HI/LO-dependent instruction in Decode would observe an unfinished result. It also serves mfhi/mflo reads and mthi/mtlo writes.

## Interface
- DATA_WIDTH, 32, operand/HI/LO width; must equal 2**CNT_WIDTH.
- CNT_WIDTH, 5, iteration counter width.

- i_CLK  in  1  core clock, rising edge.
- i_RST_n  in  1  asynchronous, active-low reset.
- i_MdStartE  in  1  valid mult/multu/div/divu in Execute (already qualified by flush).
- i_MdOpE  in  2  00 mult, 01 multu, 10 div, 11 divu.
- i_SrcAE  in  DATA_WIDTH  rs operand (dividend / multiplicand / mthi-mtlo data).
- i_SrcBE  in  DATA_WIDTH  rt operand (divisor / multiplier).
- i_MthiE  in  1  mthi in Execute.
- i_MtloE  in  1  mtlo in Execute.
- i_MfhiE  in  1  read select: 1 = HI, 0 = LO.
- i_HiLoUseD  in  1  Decode holds mfhi/mflo/mthi/mtlo/mult/multu/div/divu.
- o_HiLoOutE  out  DATA_WIDTH  combinational HI or LO per i_MfhiE.
- o_MdStallD  out  1  stall request, ORed into StallF/StallD/FlushE by the hazard unit.
- o_MdBusy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, FIX.
- IDLE: on i_MdStartE, latch |operands| (magnitudes for signed ops, raw for unsigned), record the op and result signs (prod/quot sign = signA^signB; rem sign = signA), clear the counter, and go to CALC.
- IDLE, no start: i_MthiE loads HI and i_MtloE loads LO from i_SrcAE at the edge. Both set: both load.
- CALC: one radix-2 step per cycle; counter increments.
  - Multiply: shift-add into a 2*DATA_WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter == DATA_WIDTH-1 → FIX.
- FIX: apply sign correction and write {HI,LO}, then → IDLE.
  - mult/multu: HI = product[2W-1:W], LO = product[W-1:0].
  - div/divu: LO = quotient, HI = remainder.
- Arithmetic rules:
  - Product is exact (2*DATA_WIDTH bits); signed negation is two's complement over 2W bits.
  - Signed divide: quotient truncates toward zero; remainder takes the dividend's sign.
  - 0x80000000 / -1 gives LO = 0x80000000, HI = 0.
  - Divisor 0 (signed or unsigned): LO = all ones, HI = i_SrcAE unchanged. No exception.
- Stall: o_MdStallD = i_HiLoUseD && (o_MdBusy || i_MdStartE). The i_MdStartE term covers the back-to-back case where the dependent instruction is in Decode during the start cycle.
- Illegal-by-construction inputs (i_MdStartE, i_MthiE or i_MtloE while busy): ignored, with state and HI/LO unchanged. The bench flags them with an assertion.
- i_MdStartE together with i_MthiE/i_MtloE in IDLE: start wins; the move is ignored.

## Timing
- Reset (async, immediate):
  - State IDLE, counter 0, HI = LO = 0, internal operand registers 0.
  - o_MdBusy = 0; o_HiLoOutE = 0.
  - o_MdStallD = i_MdStartE && i_HiLoUseD (combinational).
- Start sampled at edge k.
  - o_MdBusy high from after edge k through edge k+DATA_WIDTH+1 (CALC for DATA_WIDTH cycles, FIX for 1 cycle).
  - HI/LO hold new values after edge k+DATA_WIDTH+1; busy is low in the same cycle.
  - A dependent instruction held in Decode enters Execute on the cycle after busy drops and reads the new value.
- mthi/mtlo: written at the edge that ends their Execute cycle; readable by mfhi/mflo in Execute the next cycle.
- o_HiLoOutE during CALC/FIX returns the old HI/LO. This is unobservable to the program because of the stall.
- Reset asserted mid-CALC/FIX: the operation is abandoned; HI/LO = 0, IDLE. After release, no partial result is written.

## Test plan
- mult A=0xFFFFFFFD (-3), B=7 → after 33 busy cycles: HI=0xFFFFFFFF, LO=0xFFFFFFEB. multu A=0xFFFFFFFF, B=2 → HI=0x00000001, LO=0xFFFFFFFE.
- div A=0xFFFFFFF9 (-7), B=2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=100, B=7 → LO=14, HI=2. div 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- divu A=0x64, B=0 → LO=0xFFFFFFFF, HI=0x64. div A=0xFFFFFFF9, B=0 → LO=0xFFFFFFFF, HI=0xFFFFFFF9.
- Stall: mult started with mflo in Decode in the same cycle → o_MdStallD high for 34 consecutive cycles (start cycle + 33 busy), low after. mflo then returns the product's LO. An unrelated instruction in Decode during busy (i_HiLoUseD=0) → no stall.
- mthi 0x1234 then mfhi next cycle (i_MfhiE=1) → o_HiLoOutE = 0x00001234. mthi+mtlo same cycle with 0xA5A5A5A5 → both HI and LO = 0xA5A5A5A5.
- Assert i_RST_n low at CALC counter = 10 → immediately o_MdBusy=0, o_HiLoOutE=0, HI=LO=0. After release, a new mult 6*7 → LO=42, HI=0.
